gray_count_decoder: RTL and testbench

- Receive side of the Gray-coded counter interface: samples an asynchronous or foreign-domain Gray count, synchronizes it, and decodes it to binary.
- Classifies each new sample against the previous one as hold, +1 step, -1 step or illegal jump.
- Counts wrap-arounds and raises sticky error flags.
- Sits in the consuming clock domain, downstream of the Gray counter that produces the count.

---
 rtl/gray_count_decoder.sv | 185 ++++++++++++++++++
 tb/tb_gray_count_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gray_count_decoder.sv
// gray_count_decoder: synchronizes a foreign-domain Gray count, decodes it to binary and
// classifies each new sample against the previous one (hold / +1 / -1 / illegal jump).
// Latency: bin_out reflects gray_in sampled SYNC_STAGES+1 rising edges earlier.
// Backpressure: none; the decoder tracks its input every cycle and never stalls or freezes.
//
// Ports:
//   clk, resetn      clock (rising edge) and synchronous active-low reset
//   gray_in          Gray-coded count from the producer (MSB = Gray bit N-1)
//   clear_err        synchronous clear of err_sticky and wrap_cnt (a same-cycle set/increment wins)
//   bin_out          decoded binary value, qualified by bin_valid
//   step_up/step_dn  one-cycle pulses for a +1 / -1 step, aligned with the bin_out update
//   err, err_sticky  one-cycle pulse on a jump of two or more Gray bits, and its sticky copy
//   wrap_cnt         saturating count of up-wraps (all-ones -> 0)

module gray_count_decoder #(
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WRAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] gray_in,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  bin_valid,
  output logic                  step_up,
  output logic                  step_dn,
  output logic                  err,
  output logic                  err_sticky,
  output logic [WRAP_WIDTH-1:0] wrap_cnt
);

  localparam logic [0:0] ST_INIT      = 1'b0;
  localparam logic [0:0] ST_HAVE_PREV = 1'b1;

  // Fill counter runs 0..SYNC_STAGES+1 (at most 4), so 3 bits always suffice.
  localparam int             FILL_W    = 3;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES + 1);

  function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Synchronizer chain
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]            state_q,     state_d;
  logic [FILL_W-1:0]     fill_q,      fill_d;
  logic [DATA_WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic [DATA_WIDTH-1:0] bin_q,       bin_d;
  logic                  valid_q,     valid_d;
  logic                  up_q,        up_d;
  logic                  dn_q,        dn_d;
  logic                  err_q,       err_d;
  logic                  sticky_q,    sticky_d;
  logic [WRAP_WIDTH-1:0] wrap_q,      wrap_d;

  // ---------------------------------------------------------------------------
  // Classification of the newest synchronized word against the previous one
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] gray_new;
  logic [DATA_WIDTH-1:0] bin_new;
  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH-1:0] delta;
  logic                  one_bit;
  logic                  is_up;
  logic                  is_dn;
  logic                  is_jump;
  logic                  wrap_ev;

  assign gray_new = sync_q[SYNC_STAGES-1];
  assign bin_new  = gray2bin(gray_new);
  assign diff     = gray_new ^ prev_gray_q;
  assign delta    = bin_new - bin_q;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign one_bit  = (diff != '0) && ((diff & (diff - DATA_WIDTH'(1))) == '0);
  assign is_up    = one_bit && (delta == DATA_WIDTH'(1));
  assign is_dn    = one_bit && (delta == '1);
  // A single-bit change that is not +/-1 is neither a step nor an error.
  assign is_jump  = (diff != '0) && !one_bit;
  // A +1 step out of all-ones necessarily lands on zero.
  assign wrap_ev  = (state_q == ST_HAVE_PREV) && is_up && (bin_q == '1);

  always_comb begin
    state_d     = state_q;
    fill_d      = (fill_q != FILL_FULL) ? fill_q + FILL_W'(1) : fill_q;
    prev_gray_d = prev_gray_q;
    bin_d       = bin_q;
    valid_d     = valid_q;
    up_d        = 1'b0;
    dn_d        = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Load on the edge where the counter reaches SYNC_STAGES+1: the last
        // sync flop now holds the first word sampled after reset release.
        if (fill_q == FILL_LAST) begin
          bin_d       = bin_new;
          prev_gray_d = gray_new;
          valid_d     = 1'b1;
          state_d     = ST_HAVE_PREV;
        end
      end
      ST_HAVE_PREV: begin
        bin_d       = bin_new;
        prev_gray_d = gray_new;
        up_d        = is_up;
        dn_d        = is_dn;
        err_d       = is_jump;
      end
      default: state_d = ST_INIT;
    endcase

    sticky_d = err_d | (sticky_q & ~clear_err);

    if (clear_err) begin
      wrap_d = wrap_ev ? WRAP_WIDTH'(1) : '0;
    end else if (wrap_ev && (wrap_q != '1)) begin
      wrap_d = wrap_q + WRAP_WIDTH'(1);
    end else begin
      wrap_d = wrap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_INIT;
      fill_q      <= '0;
      prev_gray_q <= '0;
      bin_q       <= '0;
      valid_q     <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      wrap_q      <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      prev_gray_q <= prev_gray_d;
      bin_q       <= bin_d;
      valid_q     <= valid_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bin_out    = bin_q;
  assign bin_valid  = valid_q;
  assign step_up    = up_q;
  assign step_dn    = dn_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign wrap_cnt   = wrap_q;

endmodule

// File: tb/tb_gray_count_decoder.sv
// Directed testbench for gray_count_decoder (DATA_WIDTH=4, SYNC_STAGES=2).
// A second instance with WRAP_WIDTH=2 shares all inputs to exercise wrap saturation.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.

module tb_gray_count_decoder;

  logic       clk;
  logic       resetn;
  logic [3:0] gray_in;
  logic       clear_err;

  logic [3:0] bin_out,  s_bin_out;
  logic       bin_valid, s_bin_valid;
  logic       step_up,  s_step_up;
  logic       step_dn,  s_step_dn;
  logic       err,      s_err;
  logic       err_sticky, s_err_sticky;
  logic [7:0] wrap_cnt;
  logic [1:0] s_wrap_cnt;

  int n_asrt;
  int n_fail;
  int sh;

  gray_count_decoder #(.DATA_WIDTH(4), .SYNC_STAGES(2), .WRAP_WIDTH(8)) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .gray_in    (gray_in),
    .clear_err  (clear_err),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .err        (err),
    .err_sticky (err_sticky),
    .wrap_cnt   (wrap_cnt)
  );

  gray_count_decoder #(.DATA_WIDTH(4), .SYNC_STAGES(2), .WRAP_WIDTH(2)) u_small (
    .clk        (clk),
    .resetn     (resetn),
    .gray_in    (gray_in),
    .clear_err  (clear_err),
    .bin_out    (s_bin_out),
    .bin_valid  (s_bin_valid),
    .step_up    (s_step_up),
    .step_dn    (s_step_dn),
    .err        (s_err),
    .err_sticky (s_err_sticky),
    .wrap_cnt   (s_wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] g(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int e_bin, input int e_vld, input int e_up, input int e_dn,
                           input int e_err, input int e_stk, input int e_wrap);
    chk("bin_out",    32'(bin_out),    e_bin);
    chk("bin_valid",  32'(bin_valid),  e_vld);
    chk("step_up",    32'(step_up),    e_up);
    chk("step_dn",    32'(step_dn),    e_dn);
    chk("err",        32'(err),        e_err);
    chk("err_sticky", 32'(err_sticky), e_stk);
    chk("wrap_cnt",   32'(wrap_cnt),   e_wrap);
    chk("small_bin_out",    32'(s_bin_out),    e_bin);
    chk("small_bin_valid",  32'(s_bin_valid),  e_vld);
    chk("small_step_up",    32'(s_step_up),    e_up);
    chk("small_step_dn",    32'(s_step_dn),    e_dn);
    chk("small_err",        32'(s_err),        e_err);
    chk("small_err_sticky", 32'(s_err_sticky), e_stk);
    chk("small_wrap_cnt",   32'(s_wrap_cnt),   (e_wrap > 3) ? 3 : e_wrap);
  endtask

  // Drive one input word (and clear_err) for one edge, then check the outputs.
  task automatic step(input logic [3:0] gin, input logic clr, input int e_bin, input int e_vld,
                      input int e_up, input int e_dn, input int e_err, input int e_stk,
                      input int e_wrap);
    gray_in   = gin;
    clear_err = clr;
    tick();
    check_all(e_bin, e_vld, e_up, e_dn, e_err, e_stk, e_wrap);
  endtask

  initial begin
    n_asrt    = 0;
    n_fail    = 0;
    resetn    = 1'b0;
    gray_in   = 4'b0100;
    clear_err = 1'b0;

    // Reset state.
    tick();
    tick();
    check_all(0, 0, 0, 0, 0, 0, 0);

    // Fill: hold 0100 (7); valid on the 3rd edge after release, no pulses.
    resetn = 1'b1;
    step(4'b0100, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    step(4'b0100, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    step(4'b0100, 1'b0, 7, 1, 0, 0, 0, 0, 0);
    step(4'b0100, 1'b0, 7, 1, 0, 0, 0, 0, 0);

    // Count up 8..15,0..15,0,1,2; outputs lag the drive by two steps here.
    for (int k = 0; k <= 26; k++) begin
      sh = (k >= 2) ? (8 + k - 2) : 7;
      step(g(8 + k), 1'b0, sh % 16, 1, int'(k >= 2), 0, 0, 0, int'(sh >= 16) + int'(sh >= 32));
    end

    // Finish the up-count (1, 2, 3), then count down 3 -> 2 -> 1 -> 0 -> 15.
    step(4'b0010, 1'b0,  1, 1, 1, 0, 0, 0, 2);
    step(4'b0011, 1'b0,  2, 1, 1, 0, 0, 0, 2);
    step(4'b0001, 1'b0,  3, 1, 1, 0, 0, 0, 2);
    step(4'b0000, 1'b0,  2, 1, 0, 1, 0, 0, 2);
    step(4'b1000, 1'b0,  1, 1, 0, 1, 0, 0, 2);
    step(4'b1000, 1'b0,  0, 1, 0, 1, 0, 0, 2);
    step(4'b1000, 1'b0, 15, 1, 0, 1, 0, 0, 2);
    step(4'b1000, 1'b0, 15, 1, 0, 0, 0, 0, 2);

    // Illegal jumps 15 -> 7 -> 9, then +1 to 10 with sticky held, then clear.
    step(4'b0100, 1'b0, 15, 1, 0, 0, 0, 0, 2);
    step(4'b0100, 1'b0, 15, 1, 0, 0, 0, 0, 2);
    step(4'b1101, 1'b0,  7, 1, 0, 0, 1, 1, 2);
    step(4'b1101, 1'b0,  7, 1, 0, 0, 0, 1, 2);
    step(4'b1111, 1'b0,  9, 1, 0, 0, 1, 1, 2);
    step(4'b1111, 1'b0,  9, 1, 0, 0, 0, 1, 2);
    step(4'b1111, 1'b0, 10, 1, 1, 0, 0, 1, 2);
    step(4'b1111, 1'b1, 10, 1, 0, 0, 0, 0, 0);

    // clear_err in the same cycle as an err pulse (10 -> 12): the set wins.
    step(4'b1010, 1'b0, 10, 1, 0, 0, 0, 0, 0);
    step(4'b1010, 1'b0, 10, 1, 0, 0, 0, 0, 0);
    step(4'b1010, 1'b1, 12, 1, 0, 0, 1, 1, 0);
    step(4'b1010, 1'b0, 12, 1, 0, 0, 0, 1, 0);

    // Count up through five wraps; clear_err coincides with the sixth (15 -> 0).
    for (int v = 13; v <= 100; v++) begin
      sh = (v < 15) ? 12 : v - 2;
      step(g(v), 1'(v == 98), sh % 16, 1, int'(v >= 15), 0, 0, int'(v < 98),
           (sh >= 96) ? 1 : sh / 16);
    end

    // Mid-run reset for one edge: everything returns to zero.
    resetn = 1'b0;
    step(g(101), 1'b0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;

    // Refill, then count up through four wraps (small instance saturates at 3).
    for (int v = 102; v <= 163; v++) begin
      sh = v - 2;
      if (v < 104) begin
        step(g(v), 1'b0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        step(g(v), 1'b0, sh % 16, 1, int'(v >= 105), 0, 0, 0, sh / 16 - 6);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
